// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-back controller.
// Provides the architectural sizing constants, the write-back source
// enumeration used for round-robin state and the write-back request record.
package regfile_pkg;

    localparam int NUM_REGS = 8;
    localparam int ADDR_W   = 3;
    localparam int DATA_W   = 16;

    // Identifies which execution unit owns a write-back grant.
    typedef enum logic {
        WB_ALU = 1'b0,
        WB_MEM = 1'b1
    } wb_src_e;

    // One write-back request as presented by an execution unit.
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_ctrl_arbiter.sv
// wb_rr_arbiter: two-requester round-robin arbiter for the register-file
// write port. When both requesters are valid, the one not granted last wins.
// A lone requester is always granted. Grants are combinational and are held
// low during reset.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req_alu_i       ALU write-back request
//   req_mem_i       memory write-back request
//   gnt_alu_o       ALU granted this cycle
//   gnt_mem_o       memory granted this cycle
module wb_rr_arbiter
    import regfile_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_alu_i,
    input  logic req_mem_i,
    output logic gnt_alu_o,
    output logic gnt_mem_o
);

    wb_src_e last_q;
    wb_src_e last_d;

    // Grant selection and last-grant update.
    always_comb begin
        gnt_alu_o = 1'b0;
        gnt_mem_o = 1'b0;
        if (rst) begin
            gnt_alu_o = 1'b0;
            gnt_mem_o = 1'b0;
        end else if (req_alu_i && req_mem_i) begin
            // Conflict: favour whichever source lost the previous grant.
            gnt_alu_o = (last_q == WB_MEM);
            gnt_mem_o = (last_q == WB_ALU);
        end else begin
            gnt_alu_o = req_alu_i;
            gnt_mem_o = req_mem_i;
        end

        last_d = last_q;
        if (gnt_alu_o) begin
            last_d = WB_ALU;
        end else if (gnt_mem_o) begin
            last_d = WB_MEM;
        end else begin
            last_d = last_q;
        end
    end

    // Last-grant register; resets to MEM so the ALU wins the first conflict.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= WB_MEM;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: write-back controller and scoreboard for the register file.
// Arbitrates the single write port between ALU and memory write-back, drives
// it through a registered output stage, tracks in-flight destinations and
// stalls issue on RAW/WAW hazards.
// Optional feature macro: REGFILE_WB_BYPASS_EN -- when defined, the register
// being written by the output stage this cycle is treated as not busy by the
// hazard check.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   iss_*                             issue-stage instruction and ready
//   alu_wb_* / mem_wb_*               write-back requests and grants
//   regw_en_o, rd_addr_o, rd_data_o   registered register-file write port
//   busy_o                            scoreboard (bit i = write to reg i pending)
//   err_o                             sticky write-back-to-idle-register error
module regfile_wb_ctrl
    import regfile_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                iss_valid_i,
    input  logic [ADDR_W-1:0]   iss_rs1_addr_i,
    input  logic [ADDR_W-1:0]   iss_rs2_addr_i,
    input  logic                iss_rd_en_i,
    input  logic [ADDR_W-1:0]   iss_rd_addr_i,
    output logic                iss_ready_o,
    input  logic                alu_wb_valid_i,
    input  logic [ADDR_W-1:0]   alu_wb_addr_i,
    input  logic [DATA_W-1:0]   alu_wb_data_i,
    output logic                alu_wb_ready_o,
    input  logic                mem_wb_valid_i,
    input  logic [ADDR_W-1:0]   mem_wb_addr_i,
    input  logic [DATA_W-1:0]   mem_wb_data_i,
    output logic                mem_wb_ready_o,
    output logic                regw_en_o,
    output logic [ADDR_W-1:0]   rd_addr_o,
    output logic [DATA_W-1:0]   rd_data_o,
    output logic [NUM_REGS-1:0] busy_o,
    output logic                err_o
);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                regw_en_q, regw_en_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                err_q, err_d;

    wb_req_t             alu_req_s, mem_req_s, sel_req_s;
    logic                gnt_alu_s, gnt_mem_s, wb_fire_s, wb_write_s;
    logic [NUM_REGS-1:0] hazard_busy_s;
    logic                iss_ready_s, iss_fire_s;

    assign alu_req_s = '{valid: alu_wb_valid_i, addr: alu_wb_addr_i, data: alu_wb_data_i};
    assign mem_req_s = '{valid: mem_wb_valid_i, addr: mem_wb_addr_i, data: mem_wb_data_i};

    wb_rr_arbiter u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_alu_i (alu_req_s.valid),
        .req_mem_i (mem_req_s.valid),
        .gnt_alu_o (gnt_alu_s),
        .gnt_mem_o (gnt_mem_s)
    );

    // Hazard check against the scoreboard, optionally bypassing the active write.
    always_comb begin
        hazard_busy_s = busy_q;
`ifdef REGFILE_WB_BYPASS_EN
        if (regw_en_q) begin
            hazard_busy_s[rd_addr_q] = 1'b0;
        end else begin
            hazard_busy_s = busy_q;
        end
`endif
        if (rst) begin
            iss_ready_s = 1'b0;
        end else begin
            iss_ready_s = ~(hazard_busy_s[iss_rs1_addr_i] |
                            hazard_busy_s[iss_rs2_addr_i] |
                            (iss_rd_en_i & hazard_busy_s[iss_rd_addr_i]));
        end
        iss_fire_s = iss_valid_i & iss_ready_s;
    end

    // Granted request selection, scoreboard, error and output-stage next state.
    always_comb begin
        sel_req_s  = gnt_alu_s ? alu_req_s : mem_req_s;
        wb_fire_s  = gnt_alu_s | gnt_mem_s;
        // Writes to register 0 are accepted but never reach the register file.
        wb_write_s = wb_fire_s & (sel_req_s.addr != {ADDR_W{1'b0}});

        busy_d = busy_q;
        if (regw_en_q) begin
            busy_d[rd_addr_q] = 1'b0;
        end else begin
            busy_d = busy_q;
        end
        // Applied after the clear so a same-cycle issue to that register wins.
        if (iss_fire_s && iss_rd_en_i) begin
            busy_d[iss_rd_addr_i] = 1'b1;
        end else begin
            busy_d = busy_d;
        end
        busy_d[0] = 1'b0;

        err_d = err_q | (wb_write_s & ~busy_q[sel_req_s.addr]);

        regw_en_d = wb_write_s;
        if (wb_write_s) begin
            rd_addr_d = sel_req_s.addr;
            rd_data_d = sel_req_s.data;
        end else begin
            rd_addr_d = rd_addr_q;
            rd_data_d = rd_data_q;
        end
    end

    // State registers; reset discards pending busy bits and any staged write.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q    <= {NUM_REGS{1'b0}};
            regw_en_q <= 1'b0;
            rd_addr_q <= {ADDR_W{1'b0}};
            rd_data_q <= {DATA_W{1'b0}};
            err_q     <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            regw_en_q <= regw_en_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
            err_q     <= err_d;
        end
    end

    assign iss_ready_o    = iss_ready_s;
    assign alu_wb_ready_o = gnt_alu_s;
    assign mem_wb_ready_o = gnt_mem_s;
    assign regw_en_o      = regw_en_q;
    assign rd_addr_o      = rd_addr_q;
    assign rd_data_o      = rd_data_q;
    assign busy_o         = busy_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl: directed vector table followed by
// randomized traffic compared against a behavioural model.
module tb_regfile_wb_ctrl;

`ifdef REGFILE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        iss_valid_i, iss_rd_en_i, iss_ready_o;
    logic [2:0]  iss_rs1_addr_i, iss_rs2_addr_i, iss_rd_addr_i;
    logic        alu_wb_valid_i, mem_wb_valid_i, alu_wb_ready_o, mem_wb_ready_o;
    logic [2:0]  alu_wb_addr_i, mem_wb_addr_i;
    logic [15:0] alu_wb_data_i, mem_wb_data_i;
    logic        regw_en_o, err_o;
    logic [2:0]  rd_addr_o;
    logic [15:0] rd_data_o;
    logic [7:0]  busy_o;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    regfile_wb_ctrl dut (
        .clk(clk), .rst(rst),
        .iss_valid_i(iss_valid_i), .iss_rs1_addr_i(iss_rs1_addr_i),
        .iss_rs2_addr_i(iss_rs2_addr_i), .iss_rd_en_i(iss_rd_en_i),
        .iss_rd_addr_i(iss_rd_addr_i), .iss_ready_o(iss_ready_o),
        .alu_wb_valid_i(alu_wb_valid_i), .alu_wb_addr_i(alu_wb_addr_i),
        .alu_wb_data_i(alu_wb_data_i), .alu_wb_ready_o(alu_wb_ready_o),
        .mem_wb_valid_i(mem_wb_valid_i), .mem_wb_addr_i(mem_wb_addr_i),
        .mem_wb_data_i(mem_wb_data_i), .mem_wb_ready_o(mem_wb_ready_o),
        .regw_en_o(regw_en_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    typedef struct {
        bit        rst;
        bit        iv;
        bit [2:0]  rs1, rs2;
        bit        rde;
        bit [2:0]  rd;
        bit        av;
        bit [2:0]  aa;
        bit [15:0] ad;
        bit        mv;
        bit [2:0]  ma;
        bit [15:0] md;
        bit        e_ir, e_ar, e_mr;
        bit [7:0]  e_busy;
        bit        e_en;
        bit [2:0]  e_addr;
        bit [15:0] e_data;
        bit        e_err;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic add(input bit r, input bit iv, input bit [2:0] rs1, input bit [2:0] rs2,
                       input bit rde, input bit [2:0] rd,
                       input bit av, input bit [2:0] aa, input bit [15:0] ad,
                       input bit mv, input bit [2:0] ma, input bit [15:0] md,
                       input bit eir, input bit ear, input bit emr, input bit [7:0] eb,
                       input bit een, input bit [2:0] ea, input bit [15:0] ed, input bit ee);
        vec_t v;
        v = '{r, iv, rs1, rs2, rde, rd, av, aa, ad, mv, ma, md,
              eir, ear, emr, eb, een, ea, ed, ee};
        vq.push_back(v);
    endtask

    task automatic drive(input bit r, input bit iv, input bit [2:0] rs1, input bit [2:0] rs2,
                         input bit rde, input bit [2:0] rd,
                         input bit av, input bit [2:0] aa, input bit [15:0] ad,
                         input bit mv, input bit [2:0] ma, input bit [15:0] md);
        rst = r; iss_valid_i = iv; iss_rs1_addr_i = rs1; iss_rs2_addr_i = rs2;
        iss_rd_en_i = rde; iss_rd_addr_i = rd;
        alu_wb_valid_i = av; alu_wb_addr_i = aa; alu_wb_data_i = ad;
        mem_wb_valid_i = mv; mem_wb_addr_i = ma; mem_wb_data_i = md;
    endtask

    // Behavioural model state
    bit [7:0]  m_busy;
    bit        m_en, m_last_mem, m_err;
    bit [2:0]  m_addr;
    bit [15:0] m_data;

    function automatic bit [2:0] pick_wb();
        bit [2:0] a;
        a = 3'($urandom_range(0, 7));
        if (m_busy != 8'h00 && $urandom_range(0, 4) != 0) begin
            for (int t = 0; t < 16; t++) begin
                if (!m_busy[a]) a = 3'($urandom_range(1, 7));
            end
        end
        return a;
    endfunction

    initial begin
        drive(1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);

        //   rst iv rs1 rs2 rde rd  av aa ad       mv ma md       ir   ar mr busy   en  addr data     err
        add(1, 0, 0, 0, 0, 0,  0, 0, 16'h0,    0, 0, 16'h0,    0,   0, 0, 8'h00, 0, 0, 16'h0,    0);
        add(0, 1, 0, 0, 1, 3,  0, 0, 16'h0,    0, 0, 16'h0,    1,   0, 0, 8'h08, 0, 0, 16'h0,    0);
        add(0, 1, 3, 0, 0, 0,  0, 0, 16'h0,    0, 0, 16'h0,    0,   0, 0, 8'h08, 0, 0, 16'h0,    0);
        add(0, 1, 3, 0, 0, 0,  1, 3, 16'h0333, 0, 0, 16'h0,    0,   1, 0, 8'h08, 1, 3, 16'h0333, 0);
        add(0, 1, 3, 0, 0, 0,  0, 0, 16'h0,    0, 0, 16'h0,    BYP, 0, 0, 8'h00, 0, 0, 16'h0,    0);
        add(0, 1, 3, 0, 0, 0,  0, 0, 16'h0,    0, 0, 16'h0,    1,   0, 0, 8'h00, 0, 0, 16'h0,    0);
        add(1, 0, 0, 0, 0, 0,  0, 0, 16'h0,    0, 0, 16'h0,    0,   0, 0, 8'h00, 0, 0, 16'h0,    0);
        add(0, 1, 0, 0, 1, 1,  0, 0, 16'h0,    0, 0, 16'h0,    1,   0, 0, 8'h02, 0, 0, 16'h0,    0);
        add(0, 1, 0, 0, 1, 2,  0, 0, 16'h0,    0, 0, 16'h0,    1,   0, 0, 8'h06, 0, 0, 16'h0,    0);
        add(0, 0, 0, 0, 0, 0,  1, 1, 16'h1111, 1, 2, 16'h2222, 1,   1, 0, 8'h06, 1, 1, 16'h1111, 0);
        add(0, 0, 0, 0, 0, 0,  1, 1, 16'h1111, 1, 2, 16'h2222, 1,   0, 1, 8'h04, 1, 2, 16'h2222, 0);
        add(0, 0, 0, 0, 0, 0,  0, 0, 16'h0,    0, 0, 16'h0,    1,   0, 0, 8'h00, 0, 0, 16'h0,    0);
        add(0, 1, 0, 0, 1, 0,  0, 0, 16'h0,    0, 0, 16'h0,    1,   0, 0, 8'h00, 0, 0, 16'h0,    0);
        add(0, 0, 0, 0, 0, 0,  0, 0, 16'h0,    1, 0, 16'hBEEF, 1,   0, 1, 8'h00, 0, 0, 16'h0,    0);
        add(0, 0, 0, 0, 0, 0,  1, 5, 16'h5555, 0, 0, 16'h0,    1,   1, 0, 8'h00, 1, 5, 16'h5555, 1);
        add(0, 0, 0, 0, 0, 0,  0, 0, 16'h0,    0, 0, 16'h0,    1,   0, 0, 8'h00, 0, 0, 16'h0,    1);
        add(0, 1, 0, 0, 1, 4,  0, 0, 16'h0,    0, 0, 16'h0,    1,   0, 0, 8'h10, 0, 0, 16'h0,    1);
        add(0, 0, 0, 0, 0, 0,  1, 4, 16'h4444, 0, 0, 16'h0,    1,   1, 0, 8'h10, 1, 4, 16'h4444, 1);
        add(0, 1, 0, 0, 1, 4,  0, 0, 16'h0,    0, 0, 16'h0,    BYP, 0, 0, BYP ? 8'h10 : 8'h00, 0, 0, 16'h0, 1);
        add(1, 0, 0, 0, 0, 0,  0, 0, 16'h0,    0, 0, 16'h0,    0,   0, 0, 8'h00, 0, 0, 16'h0,    0);
        add(0, 1, 0, 0, 1, 1,  0, 0, 16'h0,    0, 0, 16'h0,    1,   0, 0, 8'h02, 0, 0, 16'h0,    0);
        add(0, 1, 0, 0, 1, 2,  0, 0, 16'h0,    0, 0, 16'h0,    1,   0, 0, 8'h06, 0, 0, 16'h0,    0);
        add(0, 1, 0, 0, 1, 3,  1, 1, 16'h0101, 0, 0, 16'h0,    1,   1, 0, 8'h0E, 1, 1, 16'h0101, 0);
        add(1, 0, 0, 0, 0, 0,  1, 2, 16'h0202, 0, 0, 16'h0,    0,   0, 0, 8'h00, 0, 0, 16'h0,    0);
        add(0, 0, 0, 0, 0, 0,  0, 0, 16'h0,    0, 0, 16'h0,    1,   0, 0, 8'h00, 0, 0, 16'h0,    0);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            drive(vq[i].rst, vq[i].iv, vq[i].rs1, vq[i].rs2, vq[i].rde, vq[i].rd,
                  vq[i].av, vq[i].aa, vq[i].ad, vq[i].mv, vq[i].ma, vq[i].md);
            #1;
            check($sformatf("vec%0d iss_ready", i), iss_ready_o, vq[i].e_ir);
            check($sformatf("vec%0d alu_ready", i), alu_wb_ready_o, vq[i].e_ar);
            check($sformatf("vec%0d mem_ready", i), mem_wb_ready_o, vq[i].e_mr);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d busy", i), busy_o, vq[i].e_busy);
            check($sformatf("vec%0d regw_en", i), regw_en_o, vq[i].e_en);
            if (vq[i].e_en) begin
                check($sformatf("vec%0d rd_addr", i), rd_addr_o, vq[i].e_addr);
                check($sformatf("vec%0d rd_data", i), rd_data_o, vq[i].e_data);
            end
            check($sformatf("vec%0d err", i), err_o, vq[i].e_err);
        end

        // Randomized traffic against the model; first cycle forces reset.
        for (int c = 0; c < 3000; c++) begin
            bit r, iv, rde, av, mv, e_ir, e_ar, e_mr, g, fire;
            bit [2:0] rs1, rs2, rd, aa, ma, ga;
            bit [15:0] ad, md, gd;
            bit [7:0] view, nb;
            @(negedge clk);
            r   = (c == 0) || ($urandom_range(0, 63) == 0);
            iv  = 1'($urandom_range(0, 1));
            rs1 = 3'($urandom_range(0, 7));
            rs2 = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
            rde = 1'($urandom_range(0, 1));
            rd  = 3'($urandom_range(0, 7));
            av  = ($urandom_range(0, 2) == 0);
            aa  = pick_wb();
            ad  = 16'($urandom);
            mv  = ($urandom_range(0, 2) == 0);
            ma  = pick_wb();
            md  = 16'($urandom);
            drive(r, iv, rs1, rs2, rde, rd, av, aa, ad, mv, ma, md);

            view = m_busy;
            if (BYP && m_en) view[m_addr] = 1'b0;
            e_ir = !r && !(view[rs1] || view[rs2] || (rde && view[rd]));
            if (r) begin
                e_ar = 1'b0; e_mr = 1'b0;
            end else if (av && mv) begin
                e_ar = m_last_mem; e_mr = !m_last_mem;
            end else begin
                e_ar = av; e_mr = mv;
            end
            #1;
            check("rnd iss_ready", iss_ready_o, e_ir);
            check("rnd alu_ready", alu_wb_ready_o, e_ar);
            check("rnd mem_ready", mem_wb_ready_o, e_mr);

            if (r) begin
                m_busy = 8'h00; m_en = 1'b0; m_addr = 3'd0; m_data = 16'h0;
                m_err = 1'b0; m_last_mem = 1'b1;
            end else begin
                nb = m_busy;
                if (m_en) nb[m_addr] = 1'b0;
                fire = iv && e_ir;
                if (fire && rde && rd != 3'd0) nb[rd] = 1'b1;
                g  = e_ar || e_mr;
                ga = e_ar ? aa : ma;
                gd = e_ar ? ad : md;
                if (g && ga != 3'd0 && !m_busy[ga]) m_err = 1'b1;
                m_en = g && ga != 3'd0;
                if (m_en) begin
                    m_addr = ga; m_data = gd;
                end
                if (g) m_last_mem = e_mr;
                m_busy = nb;
            end

            @(posedge clk);
            #1;
            check("rnd busy", busy_o, m_busy);
            check("rnd regw_en", regw_en_o, m_en);
            if (m_en) begin
                check("rnd rd_addr", rd_addr_o, m_addr);
                check("rnd rd_data", rd_data_o, m_data);
            end
            check("rnd err", err_o, m_err);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/regfile_wb_ctrl.md
# regfile_wb_ctrl

Write-back controller and scoreboard for the 8 x 16-bit register file. It arbitrates the single register-file write port between the ALU and memory write-back sources, which it drives through a registered output stage. It tracks destination registers with writes still in flight and stalls issue on RAW and WAW hazards. It sits between the issue/decode stage, the two execution units and the register file's write port.

## Interface
Parameters:
- NUM_REGS, 8, number of architectural registers; register 0 is hardwired zero
- ADDR_W, 3, register address width, equal to log2(NUM_REGS)
- DATA_W, 16, data width

Ports:
- clk  input  1  core clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- iss_valid_i  input  1  issue stage presents an instruction
- iss_rs1_addr_i / iss_rs2_addr_i  input  ADDR_W  source registers
- iss_rd_en_i  input  1  instruction writes a destination
- iss_rd_addr_i  input  ADDR_W  destination register
- iss_ready_o  output  1  no hazard; issue may fire
- alu_wb_valid_i / mem_wb_valid_i  input  1  write-back request
- alu_wb_addr_i / mem_wb_addr_i  input  ADDR_W  write-back destination
- alu_wb_data_i / mem_wb_data_i  input  DATA_W  write-back data
- alu_wb_ready_o / mem_wb_ready_o  output  1  request granted this cycle
- regw_en_o  output  1  register-file write enable
- rd_addr_o  output  ADDR_W  register-file write address
- rd_data_o  output  DATA_W  register-file write data
- busy_o  output  NUM_REGS  scoreboard; bit i set means a write to register i is pending
- err_o  output  1  sticky; set when a write-back targets a register that is not busy

## Operation
- Issue fires when iss_valid_i and iss_ready_o are both high.
- iss_ready_o is low when busy[rs1], busy[rs2], or (iss_rd_en_i and busy[rd]) is set.
  - Register 0 is never busy.
  - The source checks apply whether or not the instruction uses the source fields.
- On an issue fire with iss_rd_en_i high and rd != 0, busy[rd] is set.
- Arbitration, when both write-back sources are valid in the same cycle:
  - Round-robin using a last-grant register; the source not granted last time wins.
  - last-grant resets to MEM, so ALU wins the first conflict.
  - If only one source is valid, it is granted.
  - The ready outputs are combinational from the valid inputs and the last-grant register. A source is granted (ready high) only while its valid is high.
- Output stage: a granted request is registered into regw_en_o, rd_addr_o and rd_data_o. Every cycle the stage either loads a new request or clears regw_en_o. It never back-pressures.
- Granted write-back with address 0: accepted, regw_en_o stays low, busy is unchanged, no error.
- While regw_en_o is high, busy[rd_addr_o] clears at the end of that cycle.
  - If the same register is set by an issue fire in the same cycle, set wins.
- A granted write-back to a register whose busy bit is clear, with address != 0: the write is still performed and err_o is set. err_o clears only on rst.

## Timing
- Reset values:
  - busy_o = 0, regw_en_o = 0, rd_addr_o = 0, rd_data_o = 0, err_o = 0, last-grant = MEM.
  - While rst is high, iss_ready_o, alu_wb_ready_o and mem_wb_ready_o are forced to 0.
- Issue fire in cycle N: busy bit visible in cycle N+1.
- Write-back handshake in cycle N: regw_en_o, rd_addr_o and rd_data_o valid in cycle N+1. The busy bit reads 0 in cycle N+2.
- Minimum RAW issue-to-issue gap, no bypass, write-back accepted in cycle N: the dependent instruction issues in cycle N+2.
- rst asserted mid-operation: all pending busy bits and any write in the output stage are discarded on the next edge. No write is issued in the following cycle.

## Configuration
- REGFILE_WB_BYPASS_EN defined: the hazard check treats busy[rd_addr_o] as clear when regw_en_o is high.
  - A dependent instruction can therefore issue in cycle N+1.
  - The register-file read-during-write forwarding is outside this block.
- REGFILE_WB_BYPASS_EN undefined: the hazard check uses busy_o only.

## Structure
- Shared package regfile_pkg:
  - NUM_REGS, ADDR_W and DATA_W constants.
  - wb_src_e enum {WB_ALU, WB_MEM}, used for the last-grant state.
  - wb_req_t struct {valid, addr, data}.
- One sub-module: wb_rr_arbiter, a 2-requester round-robin arbiter with a last-grant register.
- The scoreboard, hazard check and output stage stay in the top module.

## Test plan
- Reset, then issue rd=3 fire → busy_o = 8'b0000_1000 next cycle. Issue rs1=3 → iss_ready_o = 0 until ALU write-back addr 3 is accepted. Without bypass, ready returns 2 cycles after the accept.
- ALU (addr 1, data 0x1111) and MEM (addr 2, data 0x2222) valid together for 2 cycles:
  - 1st cycle: ALU granted; rd_addr_o = 1, rd_data_o = 0x1111 one cycle later.
  - 2nd cycle: MEM granted.
- Issue with rd=0 and iss_rd_en_i=1 → busy_o unchanged. MEM write-back addr 0 → mem_wb_ready_o = 1, regw_en_o stays 0, err_o stays 0.
- ALU write-back addr 5 with busy[5]=0 → regw_en_o = 1, rd_addr_o = 5 next cycle; err_o = 1 thereafter.
- In the cycle regw_en_o writes reg 4, issue fires with rd=4 (bypass build) → busy[4] remains 1.
- busy = 0x0E and output stage valid; assert rst for 1 cycle → busy_o = 0, regw_en_o = 0 on the following cycle.
